// File: rtl/popcount_pkg.sv
// Shared constants, state type and pattern-boundary helpers for the
// popcount pattern generator.
package popcount_pkg;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Smallest WIDTH-bit value with k ones: the k low bits set.
    // Computed one bit wider so that k == WIDTH does not overflow.
    function automatic logic [WIDTH-1:0] first_pat(input logic [CW-1:0] k);
        logic [WIDTH:0] one_w;
        logic [WIDTH:0] t;
        one_w = {{WIDTH{1'b0}}, 1'b1};
        t     = (one_w << k) - one_w;
        return t[WIDTH-1:0];
    endfunction

    // Largest WIDTH-bit value with k ones: the k high bits set.
    function automatic logic [WIDTH-1:0] last_pat(input logic [CW-1:0] k);
        logic [WIDTH-1:0] f;
        f = first_pat(k);
        return f << (WIDTH - int'(k));
    endfunction

endpackage

// File: rtl/popcount_next_pattern.sv
// Combinational same-popcount successor (Gosper's hack). For an input x
// with k ones, next is the smallest larger value with k ones. All math is
// one bit wider than the pattern so the carry out of the MSB is dropped.
module popcount_next_pattern #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] next
);

    localparam int CTZW = $clog2(WIDTH + 1);

    logic [WIDTH:0] x_ext;
    logic [WIDTH:0] low_bit;
    logic [WIDTH:0] ripple;
    logic [WIDTH:0] moved;
    logic [WIDTH:0] result;
    logic [CTZW-1:0] ctz;

    assign x_ext   = {1'b0, x};
    assign low_bit = x_ext & (~x_ext + {{WIDTH{1'b0}}, 1'b1});
    assign ripple  = x_ext + low_bit;

    // Index of the lowest set bit of x (zero when x is zero).
    always_comb begin
        ctz = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (low_bit[i]) begin
                ctz = CTZW'(i);
            end
        end
    end

    // Bits displaced by the carry ripple, right-justified back to the bottom.
    assign moved  = ((ripple ^ x_ext) >> 2) >> ctz;
    assign result = ripple | moved;
    assign next   = result[WIDTH-1:0];

endmodule

// File: rtl/popcount_pattern_gen.sv
// Streams every WIDTH-bit pattern with exactly k ones, in ascending order,
// over a valid/ready handshake. One pattern per clock when the sink is ready.
module popcount_pattern_gen
    import popcount_pkg::*;
#(
    parameter int WIDTH = popcount_pkg::WIDTH,
    parameter int CW    = popcount_pkg::CW,
    parameter int NW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    count_in,
    output logic             busy,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic [WIDTH-1:0] pat_data,
    output logic             pat_last,
    output logic [NW-1:0]    pat_idx,
    output logic             done,
    output logic             err
);

    localparam logic [CW:0] MAX_K = (CW + 1)'(WIDTH);

    state_t           state_reg;
    logic [CW-1:0]    k_reg;
    logic [WIDTH-1:0] pat_data_reg;
    logic [NW-1:0]    pat_idx_reg;
    logic             pat_valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
    logic [WIDTH-1:0] pat_next;
    logic             transfer;

    popcount_next_pattern #(
        .WIDTH(WIDTH)
    ) u_next (
        .x   (pat_data_reg),
        .next(pat_next)
    );

    assign transfer  = pat_valid_reg & pat_ready;
    assign pat_valid = pat_valid_reg;
    assign pat_data  = pat_data_reg;
    assign pat_idx   = pat_idx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    // The final pattern is the one with all k ones packed at the top.
    assign pat_last  = pat_valid_reg && (pat_data_reg == last_pat(k_reg));

    // Sequence control: accept start, advance on each transfer, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            k_reg         <= '0;
            pat_data_reg  <= '0;
            pat_idx_reg   <= '0;
            pat_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if ({1'b0, count_in} > MAX_K) begin
                            err_reg <= 1'b1;
                        end else begin
                            k_reg         <= count_in;
                            pat_data_reg  <= first_pat(count_in);
                            pat_idx_reg   <= '0;
                            pat_valid_reg <= 1'b1;
                            busy_reg      <= 1'b1;
                            state_reg     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (transfer) begin
                        if (pat_last) begin
                            // Done pulses and busy drops in the same cycle.
                            pat_valid_reg <= 1'b0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= FIN;
                        end else begin
                            pat_data_reg <= pat_next;
                            pat_idx_reg  <= pat_idx_reg + NW'(1);
                        end
                    end
                end
                FIN: begin
                    // Single cycle to let done complete; start is ignored here.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Randomised bench for popcount_pattern_gen. The reference is the full
// ascending list of WIDTH-bit values with the requested popcount.
module tb_popcount_pattern_gen;
    import popcount_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CW-1:0]    count_in;
    logic             busy;
    logic             pat_valid;
    logic             pat_ready;
    logic [WIDTH-1:0] pat_data;
    logic             pat_last;
    logic [7:0]       pat_idx;
    logic             done;
    logic             err;

    int checks;
    int failures;
    int exp_q[$];

    popcount_pattern_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .count_in (count_in),
        .busy     (busy),
        .pat_valid(pat_valid),
        .pat_ready(pat_ready),
        .pat_data (pat_data),
        .pat_last (pat_last),
        .pat_idx  (pat_idx),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: every value in range with exactly k ones, ascending.
    task automatic build_exp(input int k);
        exp_q.delete();
        for (int v = 0; v < (1 << WIDTH); v++) begin
            if ($countones(v) == k) exp_q.push_back(v);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(pat_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_data"},  32'(pat_data),  32'd0);
        check({tag, "_idx"},   32'(pat_idx),   32'd0);
        check({tag, "_last"},  32'(pat_last),  32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_err"},   32'(err),       32'd0);
    endtask

    // Run a sequence for k. ready_pct sets sink readiness; start is pulsed
    // again at transfer inj_idx (if >= 0) and during FIN when fin_poke is set.
    // If stop_after >= 0 the run stops after that many transfers.
    task automatic run_seq(input int k, input int ready_pct, input int inj_idx,
                           input bit fin_poke, input int stop_after);
        int n;
        int idx;
        int budget;
        bit stalled;
        logic [WIDTH-1:0] hold_d;
        logic [7:0] hold_i;
        logic hold_l;
        int prev;
        build_exp(k);
        n = (stop_after >= 0) ? stop_after : exp_q.size();
        @(negedge clk);
        start = 1'b1;
        count_in = CW'(k);
        pat_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_valid", 32'(pat_valid), 32'd1);
        idx = 0;
        budget = 0;
        stalled = 1'b0;
        prev = -1;
        hold_d = '0;
        hold_i = '0;
        hold_l = 1'b0;
        while (idx < n && budget < 4000) begin
            check("emit_valid", 32'(pat_valid), 32'd1);
            check("emit_done", 32'(done), 32'd0);
            if (stalled) begin
                check("stall_data", 32'(pat_data), 32'(hold_d));
                check("stall_idx", 32'(pat_idx), 32'(hold_i));
                check("stall_last", 32'(pat_last), 32'(hold_l));
            end
            if (idx == inj_idx) begin
                start = 1'b1;
                count_in = CW'(2);
            end else begin
                start = 1'b0;
            end
            pat_ready = ($urandom_range(99) < ready_pct);
            if (pat_ready) begin
                $display("xfer k=%0d idx=%0d data=0x%02h last=%0d", k, idx, pat_data, pat_last);
                check("xfer_data", 32'(pat_data), 32'(exp_q[idx]));
                check("xfer_idx", 32'(pat_idx), 32'(idx));
                check("xfer_last", 32'(pat_last), 32'(idx == exp_q.size() - 1));
                check("xfer_ascending", 32'(int'(pat_data) > prev), 32'd1);
                prev = int'(pat_data);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hold_d = pat_data;
                hold_i = pat_idx;
                hold_l = pat_last;
            end
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        pat_ready = 1'b0;
        check("transfer_count", 32'(idx), 32'(n));
        if (stop_after < 0) begin
            check("fin_done", 32'(done), 32'd1);
            check("fin_busy", 32'(busy), 32'd0);
            check("fin_valid", 32'(pat_valid), 32'd0);
            if (fin_poke) begin
                start = 1'b1;
                count_in = CW'(2);
            end
            @(negedge clk);
            start = 1'b0;
            check("post_done", 32'(done), 32'd0);
            check("post_valid", 32'(pat_valid), 32'd0);
            check("post_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        count_in = '0;
        pat_ready = 1'b0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid", 32'(pat_valid), 32'd0);

        // k=3 with a permanently ready sink: 56 back-to-back transfers.
        run_seq(3, 100, -1, 1'b0, -1);
        // Single-pattern boundaries.
        run_seq(0, 100, -1, 1'b0, -1);
        run_seq(8, 100, -1, 1'b0, -1);
        // k=4 with roughly half the cycles stalled.
        run_seq(4, 50, -1, 1'b0, -1);

        // Out-of-range count: one err pulse, nothing emitted.
        @(negedge clk);
        start = 1'b1;
        count_in = CW'(9);
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_valid", 32'(pat_valid), 32'd0);
        check("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("err_clear", 32'(err), 32'd0);
        check("err_valid2", 32'(pat_valid), 32'd0);
        run_seq(1, 100, -1, 1'b0, -1);

        // Start while busy (mid-stream and during FIN) is ignored.
        run_seq(5, 70, 10, 1'b1, -1);

        // Reset after 10 transfers of k=4 drops the sequence.
        run_seq(4, 100, -1, 1'b0, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        check("rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_done2", 32'(done), 32'd0);
        check("rst_valid", 32'(pat_valid), 32'd0);
        run_seq(4, 100, -1, 1'b0, -1);

        // A few random counts with random backpressure.
        for (int r = 0; r < 3; r++) begin
            run_seq(int'($urandom_range(8)), int'($urandom_range(30, 100)), -1, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
